// File: rtl/nibble_demux.sv
// ---------------------------------------------------------------------------
// nibble_demux
//
// Time-division demultiplexer: receive-side counterpart of a 4:1 nibble
// selector. Serial WIDTH-bit words qualified by Din_valid are distributed
// round-robin into slots A, B, C, D. The four slots are published together,
// on a single clock edge, once the fourth word of a frame arrives.
//
// Ports
//   Clk          in   1      rising-edge clock
//   Reset_n      in   1      asynchronous active-low reset
//   Din          in   WIDTH  incoming word
//   Din_valid    in   1      Din carries a word this cycle
//   Sync         in   1      this cycle starts a new frame
//   A,B,C,D      out  WIDTH  slots 0..3 of the last complete frame
//   Slot         out  2      slot the next valid word will fill
//   Frame_valid  out  1      one-cycle pulse: A..D just updated
//   Frame_error  out  1      one-cycle pulse: partial frame discarded
//
// Parameters
//   WIDTH    bits per word / slot
//   TIMEOUT  idle cycles tolerated mid-frame before the partial frame is
//            dropped (must be >= 2)
// ---------------------------------------------------------------------------
module nibble_demux #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] Din,
  input  logic             Din_valid,
  input  logic             Sync,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] D,
  output logic [1:0]       Slot,
  output logic             Frame_valid,
  output logic             Frame_error
);

  // Timer only ever needs to reach TIMEOUT-1, which always fits here.
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic {
    IDLE    = 1'b0,   // nothing staged, Slot = 0
    COLLECT = 1'b1    // 1..3 words staged, Slot = 1..3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic             frame_valid_q, frame_valid_d;
  logic             frame_error_q, frame_error_d;

  // Only three staging registers: the fourth word goes straight to D on
  // the completing edge, so it never needs to be held.
  logic [WIDTH-1:0] stage_q [3];
  logic             stage_wr;
  logic [1:0]       stage_idx;

  // -------------------------------------------------------------------------
  // Next-state / output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    timer_d       = timer_q;
    a_d           = a_q;
    b_d           = b_q;
    c_d           = c_q;
    d_d           = d_q;
    frame_valid_d = 1'b0;
    frame_error_d = 1'b0;
    stage_wr      = 1'b0;
    stage_idx     = slot_q;

    if (Sync) begin
      // Sync realigns unconditionally; anything already staged is lost.
      frame_error_d = (state_q == COLLECT);
      timer_d       = '0;
      if (Din_valid) begin
        stage_wr  = 1'b1;
        stage_idx = 2'd0;
        slot_d    = 2'd1;
        state_d   = COLLECT;
      end else begin
        slot_d  = 2'd0;
        state_d = IDLE;
      end
    end else if (Din_valid) begin
      // A valid word always beats a timeout expiring in the same cycle.
      timer_d = '0;
      if (slot_q != 2'd3) begin
        stage_wr = 1'b1;
        slot_d   = slot_q + 2'd1;
        state_d  = COLLECT;
      end else begin
        a_d           = stage_q[0];
        b_d           = stage_q[1];
        c_d           = stage_q[2];
        d_d           = Din;
        frame_valid_d = 1'b1;
        slot_d        = 2'd0;
        state_d       = IDLE;
      end
    end else if (state_q == COLLECT) begin
      if (timer_q == TIMER_LAST) begin
        frame_error_d = 1'b1;
        slot_d        = 2'd0;
        state_d       = IDLE;
        timer_d       = '0;
      end else if (timer_q < TIMER_LAST) begin
        // Saturating increment: the counter can never wrap.
        timer_d = timer_q + 1'b1;
      end
    end else begin
      timer_d = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Control and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= IDLE;
      slot_q        <= 2'd0;
      timer_q       <= '0;
      a_q           <= '0;
      b_q           <= '0;
      c_q           <= '0;
      d_q           <= '0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      timer_q       <= timer_d;
      a_q           <= a_d;
      b_q           <= b_d;
      c_q           <= c_d;
      d_q           <= d_d;
      frame_valid_q <= frame_valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  // -------------------------------------------------------------------------
  // Staging registers, one per slot 0..2
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_stage
      logic [WIDTH-1:0] stage_d;

      always_comb begin
        stage_d = stage_q[gi];
        if (stage_wr && (stage_idx == 2'(gi))) begin
          stage_d = Din;
        end
      end

      always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
          stage_q[gi] <= '0;
        end else begin
          stage_q[gi] <= stage_d;
        end
      end
    end
  endgenerate

  assign A           = a_q;
  assign B           = b_q;
  assign C           = c_q;
  assign D           = d_q;
  assign Slot        = slot_q;
  assign Frame_valid = frame_valid_q;
  assign Frame_error = frame_error_q;

endmodule

// File: tb/tb_nibble_demux.sv
// ---------------------------------------------------------------------------
// tb_nibble_demux
//
// Directed, self-checking bench for nibble_demux (WIDTH=4, TIMEOUT=16).
// Inputs change 1 time unit after each rising edge; outputs are sampled at
// that same point, well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_nibble_demux;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [3:0] Din = 4'h0;
  logic       Din_valid = 1'b0;
  logic       Sync = 1'b0;
  logic [3:0] A, B, C, D;
  logic [1:0] Slot;
  logic       Frame_valid;
  logic       Frame_error;

  int checks = 0;
  int errors = 0;

  nibble_demux #(.WIDTH(4), .TIMEOUT(16)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Din         (Din),
    .Din_valid   (Din_valid),
    .Sync        (Sync),
    .A           (A),
    .B           (B),
    .C           (C),
    .D           (D),
    .Slot        (Slot),
    .Frame_valid (Frame_valid),
    .Frame_error (Frame_error)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, then release valid/sync.
  task automatic step(input logic v, input logic s, input logic [3:0] d);
    Din_valid = v;
    Sync      = s;
    Din       = d;
    @(posedge Clk);
    #1;
    Din_valid = 1'b0;
    Sync      = 1'b0;
  endtask

  // Checks slot, both pulses and the packed {A,B,C,D} after a step.
  task automatic chk_all(input string tag, input logic [1:0] slot_e,
                         input logic fv_e, input logic fe_e, input logic [15:0] abcd_e);
    chk({tag, ".slot"}, 32'(Slot), 32'(slot_e));
    chk({tag, ".fv"},   32'(Frame_valid), 32'(fv_e));
    chk({tag, ".fe"},   32'(Frame_error), 32'(fe_e));
    chk({tag, ".abcd"}, 32'({A, B, C, D}), 32'(abcd_e));
    $display("step %-10s slot=%0d fv=%0b fe=%0b abcd=%h", tag, Slot, Frame_valid, Frame_error, {A, B, C, D});
  endtask

  initial begin
    // ---------------- reset ----------------
    #12;
    chk_all("reset", 2'd0, 1'b0, 1'b0, 16'h0000);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;

    // ---------------- 1: clean frame 1,2,3,4 ----------------
    step(1'b1, 1'b0, 4'h1); chk_all("t1.w1", 2'd1, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 4'h2); chk_all("t1.w2", 2'd2, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 4'h3); chk_all("t1.w3", 2'd3, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 4'h4); chk_all("t1.w4", 2'd0, 1'b1, 1'b0, 16'h1234);
    step(1'b0, 1'b0, 4'h0); chk_all("t1.idle", 2'd0, 1'b0, 1'b0, 16'h1234);

    // ---------------- 2: Sync mid-frame ----------------
    step(1'b1, 1'b0, 4'h5); chk_all("t2.w5", 2'd1, 1'b0, 1'b0, 16'h1234);
    step(1'b1, 1'b0, 4'h6); chk_all("t2.w6", 2'd2, 1'b0, 1'b0, 16'h1234);
    step(1'b1, 1'b1, 4'h9); chk_all("t2.sync", 2'd1, 1'b0, 1'b1, 16'h1234);
    step(1'b1, 1'b0, 4'hA); chk_all("t2.wA", 2'd2, 1'b0, 1'b0, 16'h1234);
    step(1'b1, 1'b0, 4'hB); chk_all("t2.wB", 2'd3, 1'b0, 1'b0, 16'h1234);
    step(1'b1, 1'b0, 4'hC); chk_all("t2.wC", 2'd0, 1'b1, 1'b0, 16'h9ABC);

    // ---------------- 3: timeout after 16 idle cycles ----------------
    step(1'b1, 1'b0, 4'h7);
    step(1'b1, 1'b0, 4'h8); chk_all("t3.w8", 2'd2, 1'b0, 1'b0, 16'h9ABC);
    for (int i = 1; i <= 15; i++) begin
      step(1'b0, 1'b0, 4'h0);
      chk("t3.idle.fe", 32'(Frame_error), 32'd0);
    end
    chk_all("t3.idle15", 2'd2, 1'b0, 1'b0, 16'h9ABC);
    step(1'b0, 1'b0, 4'h0); chk_all("t3.idle16", 2'd0, 1'b0, 1'b1, 16'h9ABC);
    step(1'b0, 1'b0, 4'h0); chk_all("t3.after", 2'd0, 1'b0, 1'b0, 16'h9ABC);
    step(1'b1, 1'b0, 4'h1);
    step(1'b1, 1'b0, 4'h3);
    step(1'b1, 1'b0, 4'h5);
    step(1'b1, 1'b0, 4'h7); chk_all("t3.frame", 2'd0, 1'b1, 1'b0, 16'h1357);

    // ---------------- 4: 15-cycle gaps never time out ----------------
    step(1'b1, 1'b0, 4'h2);
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 15; i++) begin
        step(1'b0, 1'b0, 4'h0);
        chk("t4.gap.fe", 32'(Frame_error), 32'd0);
      end
      chk("t4.gap.slot", 32'(Slot), 32'(w + 1));
      step(1'b1, 1'b0, 4'(2 * (w + 2)));
    end
    chk_all("t4.frame", 2'd0, 1'b1, 1'b0, 16'h2468);

    // ---------------- 5: async reset mid-frame ----------------
    step(1'b1, 1'b0, 4'hA);
    step(1'b1, 1'b0, 4'hB); chk_all("t5.pre", 2'd2, 1'b0, 1'b0, 16'h2468);
    #2;
    Reset_n = 1'b0;
    #1;
    chk_all("t5.async", 2'd0, 1'b0, 1'b0, 16'h0000);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    step(1'b1, 1'b0, 4'hE); chk_all("t5.wE", 2'd1, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 4'hF);
    step(1'b1, 1'b0, 4'h0);
    step(1'b1, 1'b0, 4'h1); chk_all("t5.frame", 2'd0, 1'b1, 1'b0, 16'hEF01);

    // ---------------- 6: Sync in IDLE ----------------
    step(1'b0, 1'b1, 4'h0); chk_all("t6.sync", 2'd0, 1'b0, 1'b0, 16'hEF01);
    step(1'b1, 1'b1, 4'h3); chk_all("t6.syncv", 2'd1, 1'b0, 1'b0, 16'hEF01);
    step(1'b1, 1'b0, 4'h4);
    step(1'b1, 1'b0, 4'h5);
    step(1'b1, 1'b0, 4'h6); chk_all("t6.frame", 2'd0, 1'b1, 1'b0, 16'h3456);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
